imem_ctrl: RTL and testbench
============================

Name: imem_ctrl

Overview:
Single-port controller in front of the word-addressed instruction memory. It shares the memory between the processor fetch port and a program-loader write port. It also performs a hardware zero-fill of the whole array on reset or on command, so successive test programs never see stale words. The memory array itself stays combinational-read and write-on-clock. This block owns address, write data and write enable to it.

Parameters:
AW, 10, word-address width; array depth is 2^AW words
DW, 32, data word width
CLEAR_ON_RESET, 1, 1 = enter zero-fill after reset; 0 = go straight to RUN

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
f_req  input  1  fetch request; held high for back-to-back fetches
f_addr  input  AW  fetch word address
f_ack  output  1  registered; pulses the cycle after a fetch is granted
f_rdata  output  DW  registered fetch data, valid when f_ack=1, held otherwise
l_wvalid  input  1  loader write request
l_waddr  input  AW  loader word address
l_wdata  input  DW  loader write data
l_wready  output  1  combinational; write accepted this cycle when l_wvalid & l_wready
l_clear  input  1  start zero-fill (level sampled each cycle)
busy  output  1  1 while in CLEAR state
clear_done  output  1  one-cycle pulse after the last zero word is written
m_addr  output  AW  memory word address
m_wdata  output  DW  memory write data
m_we  output  1  memory write enable
m_rdata  input  DW  memory combinational read data

Behaviour:
- Two states: CLEAR and RUN. A clear counter clr_cnt is AW bits wide. A fairness bit f_prio is set after a write is granted while f_req is high.
- Reset (sync, high):
  - state <= CLEAR if CLEAR_ON_RESET, else RUN.
  - clr_cnt, f_prio, f_ack, clear_done <= 0.
  - f_rdata <= 0.
  - Reset beats every other input, including mid-clear: a reset mid-clear restarts the fill at address 0.
- CLEAR:
  - m_we=1, m_addr=clr_cnt, m_wdata=0; clr_cnt increments each cycle.
  - Fetch and loader are stalled: l_wready=0, no fetch grant.
  - busy=1.
  - When clr_cnt = 2^AW-1 the word is written, state <= RUN, clr_cnt <= 0, and clear_done pulses the next cycle. Total duration is exactly 2^AW cycles.
  - l_clear=1 during CLEAR resets clr_cnt to 0 next cycle; the fill restarts.
- RUN, per-cycle arbitration, in priority order:
  1. l_clear=1: nothing is granted this cycle (l_wready=0, m_we=0). state <= CLEAR next cycle.
  2. l_wvalid=1 and not (f_req & f_prio):
     - Write grant: l_wready=1, m_we=1, m_addr=l_waddr, m_wdata=l_wdata.
     - f_prio <= f_req.
  3. f_req=1:
     - Fetch grant: m_addr=f_addr, m_we=0.
     - f_rdata <= m_rdata and f_ack <= 1 at the next edge.
     - f_prio <= 0.
  4. Idle: m_addr=f_addr, m_we=0, m_wdata=0.
- f_ack is 0 on any cycle following a non-fetch-grant cycle.
- Fetch latency: exactly 1 cycle. Throughput: 1 word/cycle with no loader traffic.
- Write then fetch of the same address in the next cycle returns the new data (write lands at edge N, read at N+1).
- Under continuous conflict, write and fetch grants strictly alternate; neither port starves.
- m_we is never asserted outside a write grant or CLEAR.
- No address wrap logic is needed: all addresses are AW bits and in range.

Test Plan:
1. AW=4, CLEAR_ON_RESET=1: reset high 2 cycles, then release.
   -> busy=1 for 16 cycles, m_we=1 with m_addr 0..15, clear_done pulses on cycle 17.
   -> Subsequent fetches of all 16 addresses return 0x00000000.
2. RUN: write 0xDEADBEEF to addr 5, then f_req with f_addr=5 next cycle.
   -> f_ack=1 one cycle later with f_rdata=0xDEADBEEF.
3. l_wvalid and f_req held high together for 6 cycles.
   -> l_wready sequence 1,0,1,0,1,0 and f_ack sequence (one cycle delayed) 0,1,0,1,0,1.
4. l_clear pulse while loader writes are streaming.
   -> l_wready=0 that cycle, busy=1 for 2^AW cycles.
   -> Previously written addresses read back 0.
5. Reset asserted at clr_cnt=7 during CLEAR.
   -> After release, m_addr restarts at 0 and clear_done comes 2^AW cycles later.
6. CLEAR_ON_RESET=0, memory preloaded with the address pattern, f_req held high and f_addr incremented each cycle.
   -> f_ack high every cycle after the first, f_rdata matches the pattern, busy never asserts.

Source files
------------

// File: rtl/imem_ctrl.sv
// Instruction memory controller: arbitrates one single-port array between the
// fetch port and the program loader, and zero-fills the array on reset or on
// an explicit clear command.
module imem_ctrl #(
  parameter int unsigned AW             = 10,
  parameter int unsigned DW             = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  // Fetch port
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  // Loader write port
  input  logic          l_wvalid,
  input  logic [AW-1:0] l_waddr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_wready,
  // Zero-fill control
  input  logic          l_clear,
  output logic          busy,
  output logic          clear_done,
  // Memory array side
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_we,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic {StClear, StRun} state_e;

  localparam logic [AW-1:0] ClrLast = {AW{1'b1}};

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          f_prio_q, f_prio_d;
  logic          f_ack_q;
  logic          clear_done_q, clear_done_d;
  logic [DW-1:0] f_rdata_q;
  logic          fetch_grant;

  // Next-state and memory-side arbitration.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    f_prio_d     = f_prio_q;
    clear_done_d = 1'b0;
    fetch_grant  = 1'b0;
    m_addr       = f_addr;
    m_wdata      = '0;
    m_we         = 1'b0;
    l_wready     = 1'b0;
    busy         = 1'b0;

    unique case (state_q)
      StClear: begin
        busy   = 1'b1;
        m_we   = 1'b1;
        m_addr = clr_cnt_q;
        if (l_clear) begin
          // A repeated clear restarts the fill from the bottom.
          clr_cnt_d = '0;
        end else if (clr_cnt_q == ClrLast) begin
          state_d      = StRun;
          clr_cnt_d    = '0;
          clear_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      StRun: begin
        if (l_clear) begin
          // Grant nothing this cycle; clr_cnt_q is already zero here.
          state_d = StClear;
        end else if (l_wvalid && !(f_req && f_prio_q)) begin
          l_wready = 1'b1;
          m_we     = 1'b1;
          m_addr   = l_waddr;
          m_wdata  = l_wdata;
          // Next conflict goes to the fetch port.
          f_prio_d = f_req;
        end else if (f_req) begin
          fetch_grant = 1'b1;
          f_prio_d    = 1'b0;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // State, counter and registered fetch response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR_ON_RESET ? StClear : StRun;
      clr_cnt_q    <= '0;
      f_prio_q     <= 1'b0;
      f_ack_q      <= 1'b0;
      clear_done_q <= 1'b0;
      f_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      f_prio_q     <= f_prio_d;
      f_ack_q      <= fetch_grant;
      clear_done_q <= clear_done_d;
      if (fetch_grant) begin
        f_rdata_q <= m_rdata;
      end
    end
  end

  assign f_ack      = f_ack_q;
  assign f_rdata    = f_rdata_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with AW=4: one instance clearing on reset, one
// starting directly in RUN. Each instance has a behavioural memory array.
module tb_imem_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned Depth = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance 1 (CLEAR_ON_RESET=1)
  logic          f_req, f_ack, l_wvalid, l_wready, l_clear, busy, clear_done, m_we;
  logic [AW-1:0] f_addr, l_waddr, m_addr;
  logic [DW-1:0] f_rdata, l_wdata, m_wdata, m_rdata;
  logic [DW-1:0] mem1 [Depth];

  // Instance 2 (CLEAR_ON_RESET=0)
  logic          f_req2, f_ack2, l_wvalid2, l_wready2, l_clear2, busy2, clear_done2, m_we2;
  logic [AW-1:0] f_addr2, l_waddr2, m_addr2;
  logic [DW-1:0] f_rdata2, l_wdata2, m_wdata2, m_rdata2;
  logic [DW-1:0] mem2 [Depth];

  imem_ctrl #(.AW(AW), .DW(DW), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .l_wvalid(l_wvalid), .l_waddr(l_waddr), .l_wdata(l_wdata), .l_wready(l_wready),
    .l_clear(l_clear), .busy(busy), .clear_done(clear_done),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata)
  );

  imem_ctrl #(.AW(AW), .DW(DW), .CLEAR_ON_RESET(1'b0)) u_dut2 (
    .clk(clk), .reset(reset),
    .f_req(f_req2), .f_addr(f_addr2), .f_ack(f_ack2), .f_rdata(f_rdata2),
    .l_wvalid(l_wvalid2), .l_waddr(l_waddr2), .l_wdata(l_wdata2), .l_wready(l_wready2),
    .l_clear(l_clear2), .busy(busy2), .clear_done(clear_done2),
    .m_addr(m_addr2), .m_wdata(m_wdata2), .m_we(m_we2), .m_rdata(m_rdata2)
  );

  // Combinational-read, write-on-clock arrays.
  always @(posedge clk) begin
    if (m_we) mem1[m_addr] <= m_wdata;
    if (m_we2) mem2[m_addr2] <= m_wdata2;
  end
  assign m_rdata  = mem1[m_addr];
  assign m_rdata2 = mem2[m_addr2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance 2 must never enter CLEAR once out of reset.
  logic busy2_seen = 1'b0;
  always @(negedge clk) begin
    if (!reset && busy2 === 1'b1) busy2_seen <= 1'b1;
  end

  logic [5:0] exp_wr;
  logic [5:0] exp_ack;

  initial begin
    f_req = 0; f_addr = '0; l_wvalid = 0; l_waddr = '0; l_wdata = '0; l_clear = 0;
    f_req2 = 0; f_addr2 = '0; l_wvalid2 = 0; l_waddr2 = '0; l_wdata2 = '0; l_clear2 = 0;
    exp_wr  = 6'b010101;  // bit k = cycle k
    exp_ack = 6'b101010;

    // 1. Reset two cycles, then zero-fill of all 16 words.
    tick();
    check("rst_f_ack", 32'(f_ack), 32'd0);
    check("rst_clear_done", 32'(clear_done), 32'd0);
    check("rst_f_rdata", f_rdata, 32'd0);
    tick();
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("clr_busy_%0d", i), 32'(busy), 32'd1);
      check($sformatf("clr_we_%0d", i), 32'(m_we), 32'd1);
      check($sformatf("clr_addr_%0d", i), 32'(m_addr), 32'(i));
      check($sformatf("clr_done_early_%0d", i), 32'(clear_done), 32'd0);
      tick();
    end
    check("clr_done_pulse", 32'(clear_done), 32'd1);
    check("clr_busy_off", 32'(busy), 32'd0);
    f_req = 1;
    for (int i = 0; i < 16; i++) begin
      f_addr = AW'(i);
      tick();
      check($sformatf("zfetch_ack_%0d", i), 32'(f_ack), 32'd1);
      check($sformatf("zfetch_data_%0d", i), f_rdata, 32'd0);
    end
    f_req = 0;
    tick();
    check("idle_ack_low", 32'(f_ack), 32'd0);

    // 2. Write then fetch the same address on the next cycle.
    l_wvalid = 1; l_waddr = 4'd5; l_wdata = 32'hDEADBEEF;
    #1;
    check("wr_ready", 32'(l_wready), 32'd1);
    check("wr_we", 32'(m_we), 32'd1);
    tick();
    l_wvalid = 0; f_req = 1; f_addr = 4'd5;
    #1;
    check("rd_we_low", 32'(m_we), 32'd0);
    tick();
    check("raw_ack", 32'(f_ack), 32'd1);
    check("raw_data", f_rdata, 32'hDEADBEEF);
    f_req = 0;
    tick();

    // 3. Continuous conflict: grants alternate, write first.
    l_wvalid = 1; f_req = 1; f_addr = 4'd5;
    for (int k = 0; k < 6; k++) begin
      l_waddr = AW'(8 + k);
      l_wdata = 32'h1000 + 32'(k);
      #1;
      check($sformatf("alt_wready_%0d", k), 32'(l_wready), 32'(exp_wr[k]));
      tick();
      check($sformatf("alt_ack_%0d", k), 32'(f_ack), 32'(exp_ack[k]));
      if (exp_ack[k]) check($sformatf("alt_data_%0d", k), f_rdata, 32'hDEADBEEF);
    end
    l_wvalid = 0; f_req = 0;
    tick();
    // Confirm the interleaved write landed.
    f_req = 1; f_addr = 4'd10;
    tick();
    check("alt_wr_landed", f_rdata, 32'h1002);
    f_req = 0;
    tick();

    // 4. l_clear while the loader is streaming.
    l_wvalid = 1; l_waddr = 4'd3; l_wdata = 32'h33;
    #1;
    check("stream_ready", 32'(l_wready), 32'd1);
    tick();
    l_waddr = 4'd4; l_wdata = 32'h44; l_clear = 1;
    #1;
    check("lclr_wready", 32'(l_wready), 32'd0);
    check("lclr_we", 32'(m_we), 32'd0);
    tick();
    l_clear = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("lclr_busy_%0d", i), 32'(busy), 32'd1);
      check($sformatf("lclr_stall_%0d", i), 32'(l_wready), 32'd0);
      check($sformatf("lclr_addr_%0d", i), 32'(m_addr), 32'(i));
      tick();
      if (i == 15) l_wvalid = 0;
    end
    check("lclr_done", 32'(clear_done), 32'd1);
    check("lclr_busy_off", 32'(busy), 32'd0);
    f_req = 1;
    f_addr = 4'd3;  tick(); check("lclr_rd3", f_rdata, 32'd0);
    f_addr = 4'd5;  tick(); check("lclr_rd5", f_rdata, 32'd0);
    f_addr = 4'd10; tick(); check("lclr_rd10", f_rdata, 32'd0);
    f_req = 0;
    tick();

    // 5. Reset mid-clear at clr_cnt=7 restarts the fill.
    l_clear = 1;
    tick();
    l_clear = 0;
    for (int i = 0; i < 7; i++) tick();
    #1;
    check("mid_addr7", 32'(m_addr), 32'd7);
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("rclr_addr_%0d", i), 32'(m_addr), 32'(i));
      check($sformatf("rclr_done_early_%0d", i), 32'(clear_done), 32'd0);
      tick();
    end
    check("rclr_done", 32'(clear_done), 32'd1);

    // 6. Instance 2: preload address pattern, then streaming fetch.
    l_wvalid2 = 1;
    for (int i = 0; i < 16; i++) begin
      l_waddr2 = AW'(i);
      l_wdata2 = 32'(i);
      #1;
      check($sformatf("pre_ready_%0d", i), 32'(l_wready2), 32'd1);
      tick();
    end
    l_wvalid2 = 0;
    f_req2 = 1;
    for (int i = 0; i < 16; i++) begin
      f_addr2 = AW'(i);
      tick();
      check($sformatf("stream_ack_%0d", i), 32'(f_ack2), 32'd1);
      check($sformatf("stream_data_%0d", i), f_rdata2, 32'(i));
    end
    f_req2 = 0;
    tick();
    check("nc_busy_never", 32'(busy2_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
